// File: rtl/matrix_scan_ctrl.sv
// Row-scan controller for a double-buffered LED matrix: one row lit at a time,
// blanking between rows, front/back bank swap deferred to the frame boundary.
module matrix_scan_ctrl #(
  parameter int ROW       = 8,
  parameter int BIT_COUNT = 3,
  parameter int COL       = 8,
  parameter int DWELL     = 1000,
  parameter int BLANK     = 4,
  parameter int CNT_W     = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [BIT_COUNT-1:0] wr_row,
  input  logic [COL-1:0]       wr_data,
  input  logic                 swap_req,
  output logic                 swap_pending,
  output logic                 swap_ack,
  output logic                 frame_start,
  output logic [ROW-1:0]       row_sel,
  output logic [COL-1:0]       col_data
);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  localparam logic [BIT_COUNT-1:0] LAST_ROW   = BIT_COUNT'(ROW - 1);
  localparam logic [CNT_W-1:0]     BLANK_LAST = CNT_W'(BLANK - 1);
  localparam logic [CNT_W-1:0]     DWELL_LAST = CNT_W'(DWELL - 1);

  state_t               state, state_nxt;
  logic [BIT_COUNT-1:0] row_idx, row_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic                 front, front_nxt;
  logic                 boundary;
  logic                 wr_in_range;
  logic [COL-1:0]       frame_mem [2][ROW];

  // Next scan position; outputs are registered from it so they line up with state.
  always_comb begin
    state_nxt = state;
    row_nxt   = row_idx;
    cnt_nxt   = cnt + 1'b1;
    boundary  = 1'b0;
    case (state)
      ST_BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_nxt = ST_SHOW;
          cnt_nxt   = '0;
        end
      end
      ST_SHOW: begin
        if (cnt == DWELL_LAST) begin
          state_nxt = ST_BLANK;
          cnt_nxt   = '0;
          boundary  = (row_idx == LAST_ROW);
          row_nxt   = boundary ? '0 : row_idx + 1'b1;
        end
      end
      default: state_nxt = ST_BLANK;
    endcase
    front_nxt   = front ^ (boundary & swap_pending);
    wr_in_range = (int'(wr_row) < ROW);
  end

  // NOTE: state and outputs use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_BLANK;
      row_idx      <= '0;
      cnt          <= '0;
      front        <= 1'b0;
      swap_pending <= 1'b0;
      swap_ack     <= 1'b0;
      frame_start  <= 1'b0;
      row_sel      <= '0;
      col_data     <= '0;
    end else begin
      state       <= state_nxt;
      row_idx     <= row_nxt;
      cnt         <= cnt_nxt;
      front       <= front_nxt;
      frame_start <= boundary;
      swap_ack    <= boundary & swap_pending;
      if (boundary && swap_pending) begin
        swap_pending <= 1'b0;
      end else if (swap_req && !swap_pending) begin
        swap_pending <= 1'b1;
      end
      if (state_nxt == ST_SHOW) begin
        row_sel  <= ROW'(1) << row_nxt;
        col_data <= frame_mem[front_nxt][row_nxt];
      end else begin
        row_sel  <= '0;
        col_data <= '0;
      end
    end
  end

  // NOTE: the frame store is reset because a cleared display after reset is
  // part of the block's contract; this rules out RAM inference on purpose.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < ROW; r++) begin
          frame_mem[b][r] <= '0;
        end
      end
    end else if (wr_en && wr_in_range && !swap_pending) begin
      frame_mem[~front][wr_row] <= wr_data;
    end
  end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Self-checking bench for matrix_scan_ctrl: directed plus random stimulus checked
// every cycle against a frame-position model of the scan and bank swap.
module tb_matrix_scan_ctrl;

  localparam int ROW   = 8;
  localparam int COL   = 8;
  localparam int DWELL = 4;
  localparam int BLANK = 2;
  localparam int PER   = BLANK + DWELL;
  localparam int FRAME = ROW * PER;

  logic           clk = 1'b0;
  logic           rst;
  logic           wr_en;
  logic [2:0]     wr_row;
  logic [COL-1:0] wr_data;
  logic           swap_req;
  logic           swap_pending;
  logic           swap_ack;
  logic           frame_start;
  logic [ROW-1:0] row_sel;
  logic [COL-1:0] col_data;

  int checks = 0;
  int errors = 0;

  // Reference model: displayed and hidden images, pending flag, cycle count
  // since reset release (cycle 0 is the first blank cycle of row 0).
  logic [COL-1:0] m_front [ROW];
  logic [COL-1:0] m_back  [ROW];
  bit             m_pending;
  bit             m_ack;
  bit             m_fs;
  int             t;

  matrix_scan_ctrl #(
    .ROW(ROW), .BIT_COUNT(3), .COL(COL), .DWELL(DWELL), .BLANK(BLANK), .CNT_W(10)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
    .swap_req(swap_req), .swap_pending(swap_pending), .swap_ack(swap_ack),
    .frame_start(frame_start), .row_sel(row_sel), .col_data(col_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < ROW; r++) begin
      m_front[r] = '0;
      m_back[r]  = '0;
    end
    m_pending = 0;
    m_ack     = 0;
    m_fs      = 0;
    t         = 0;
  endtask

  task automatic check_outputs();
    int pos, r;
    bit show;
    logic [ROW-1:0] exp_sel;
    logic [COL-1:0] exp_col;
    pos     = t % FRAME;
    r       = pos / PER;
    show    = (pos % PER) >= BLANK;
    exp_sel = show ? ROW'(1) << r : '0;
    exp_col = show ? m_front[r] : '0;
    check("row_sel", 32'(row_sel), 32'(exp_sel));
    check("col_data", 32'(col_data), 32'(exp_col));
    check("frame_start", 32'(frame_start), 32'(m_fs));
    check("swap_ack", 32'(swap_ack), 32'(m_ack));
    check("swap_pending", 32'(swap_pending), 32'(m_pending));
  endtask

  // One clock: drive inputs, advance the model across the edge, check at negedge.
  task automatic cyc(input bit we, input logic [2:0] r, input logic [COL-1:0] d, input bit sr);
    logic [COL-1:0] tmp;
    wr_en = we; wr_row = r; wr_data = d; swap_req = sr;
    @(posedge clk);
    t++;
    m_fs  = (t % FRAME) == 0;
    m_ack = 0;
    if (we && !m_pending && int'(r) < ROW) m_back[r] = d;
    if (m_fs && m_pending) begin
      for (int i = 0; i < ROW; i++) begin
        tmp        = m_front[i];
        m_front[i] = m_back[i];
        m_back[i]  = tmp;
      end
      m_pending = 0;
      m_ack     = 1;
    end else if (sr && !m_pending) begin
      m_pending = 1;
    end
    @(negedge clk);
    wr_en = 0; swap_req = 0;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 3'd0, '0, 0);
  endtask

  initial begin
    rst = 1'b1; wr_en = 0; wr_row = '0; wr_data = '0; swap_req = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    rst = 1'b0;
    check_outputs();

    // Idle scan over two frames: blank display, frame_start at 48 and 96.
    idle(2 * FRAME + 4);

    // Load a full frame and swap it in.
    for (int r = 0; r < ROW; r++) cyc(1, 3'(r), COL'(8'h11 * (r + 1)), 0);
    cyc(0, 3'd0, '0, 1);
    idle(FRAME + 10);

    // Back-buffer writes without a swap leave the display unchanged.
    for (int r = 0; r < ROW; r++) cyc(1, 3'(r), 8'hFF, 0);
    idle(3 * FRAME);

    // Pending lockout: dropped write and ignored second request.
    cyc(0, 3'd0, '0, 1);
    cyc(1, 3'd3, 8'h5A, 0);
    cyc(0, 3'd0, '0, 1);
    idle(FRAME + 4);
    cyc(0, 3'd0, '0, 1);
    idle(FRAME + 4);

    // Coincident write and swap request.
    cyc(1, 3'd0, 8'hC3, 1);
    idle(FRAME + 4);

    // Random traffic, including requests landing on frame-boundary edges.
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), COL'($urandom),
          ($urandom_range(0, 30) == 0) || ((t + 1) % FRAME == 0 && $urandom_range(0, 1) == 1));
    end

    // Reset asserted during row 5 SHOW with a swap pending.
    while (t % FRAME != 2) idle(1);
    cyc(0, 3'd0, '0, 1);
    while (t % FRAME != 33) idle(1);
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    repeat (2) @(negedge clk);
    check_outputs();
    rst = 1'b0;
    check_outputs();
    idle(FRAME + 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_scan_ctrl.md
# matrix_scan_ctrl

Row-scan controller for the pong LED matrix. It holds a double-buffered ROW x COL frame, time-multiplexes one row at a time onto the matrix drivers, and inserts a blanking gap between rows to prevent ghosting. Game logic writes the next frame into the back buffer and requests a swap. The controller performs the swap only at a frame boundary, so a displayed frame never tears.

## Interface
Parameters:
- ROW, 8, matrix rows (one lit at a time)
- BIT_COUNT, 3, width of the row index; ceil(log2(ROW))
- COL, 8, LEDs per row (bits per frame row)
- DWELL, 1000, clk cycles each row is lit; must be >= 1
- BLANK, 4, clk cycles all rows are off before each row is lit; must be >= 1
- CNT_W, 10, phase counter width; 2^CNT_W must be >= max(DWELL, BLANK)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- wr_en  in  1  write one row of the back buffer this cycle
- wr_row  in  BIT_COUNT  row index for the write; values >= ROW are ignored
- wr_data  in  COL  row pixel data, bit i = column i, 1 = lit
- swap_req  in  1  single-cycle request to swap front and back buffers
- swap_pending  out  1  swap accepted but not yet performed
- swap_ack  out  1  one-cycle pulse: swap performed
- frame_start  out  1  one-cycle pulse: a new frame scan begins
- row_sel  out  ROW  one-hot row enable, active-high; all 0 = blanked
- col_data  out  COL  column drive for the selected row, active-high

## Operation
- Reset state:
  - FSM in BLANK, row index 0, phase counter 0, front bank 0.
  - Both buffers cleared; swap_pending = 0.
  - All outputs 0.
  - Reset asserted mid-scan aborts immediately (asynchronous); no swap_ack is issued for a pending swap.
- FSM states:
  - BLANK:
    - row_sel = 0, col_data = 0.
    - Counter counts 0..BLANK-1; at BLANK-1 go to SHOW with counter 0.
  - SHOW:
    - row_sel = one-hot(row index), col_data = front[row index].
    - Counter counts 0..DWELL-1; at DWELL-1 go to BLANK with counter 0.
    - Row index increments and wraps from ROW-1 to 0.
- Frame boundary:
  - Defined as the SHOW->BLANK transition out of row ROW-1.
  - frame_start pulses in the first BLANK cycle of row 0.
  - frame_start does not pulse after reset.
- Writes:
  - wr_en with wr_row < ROW and swap_pending = 0 writes wr_data into back[wr_row] at the clock edge.
  - Writes while swap_pending = 1 are dropped.
  - The front buffer is never writable.
- Swap handshake:
  - swap_req with swap_pending = 0 sets swap_pending on the next edge.
  - swap_req while pending is ignored; requests do not queue.
  - At the frame boundary with swap_pending = 1: front bank toggles, swap_pending clears, and swap_ack pulses in the same cycle as frame_start.
  - swap_req and wr_en in the same cycle with pending = 0: the write is performed and the swap is accepted.
  - swap_req arriving in the cycle of the frame-boundary edge is accepted for the following frame.
- The back buffer is not copied on swap. After a swap, the new back buffer holds the previously displayed frame.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Row period is BLANK+DWELL cycles; frame period is ROW*(BLANK+DWELL) cycles.
- After rst deasserts, row 0 is blanked for BLANK cycles, then lit for DWELL cycles.
- col_data is stable for the full DWELL window. It changes only on BLANK->SHOW and SHOW->BLANK edges.
- A row written to the back buffer appears in row 0's SHOW window of the frame following swap_ack. The earliest it can appear is BLANK cycles after swap_ack.
- Pulse widths:
  - swap_ack and frame_start are exactly 1 cycle.
  - swap_pending stays high from the cycle after an accepted swap_req through the cycle before swap_ack.
- Row index and counter wrap without a gap cycle. row_sel is never multi-hot.

## Test plan
Parameters for all tests: ROW=8, COL=8, DWELL=4, BLANK=2; frame = 48 cycles.

- Reset and idle scan:
  - Stimulus: release rst and run 2 frames.
  - Required: row_sel is 0 for 2 cycles, then 8'h01 for 4 cycles, 0 for 2, then 8'h02 ... through 8'h80, then 8'h01 again.
  - Required: col_data stays 0 throughout.
  - Required: frame_start pulses at cycles 48 and 96 after release.
- Frame load and swap:
  - Stimulus: write back rows 0..7 with 8'h11*(r+1) (row 7 = 8'h88), then pulse swap_req.
  - Required: swap_pending goes high the next cycle.
  - Required: swap_ack and frame_start are coincident at the next boundary.
  - Required: the following SHOW windows show col_data 8'h11, 8'h22, ... 8'h88 with matching row_sel.
- No swap, no change:
  - Stimulus: write 8'hFF to every back row without swap_req.
  - Required: displayed col_data is unchanged over 3 frames; swap_ack never pulses.
- Pending lockout:
  - Stimulus: after an accepted swap_req, issue wr_en row 3 = 8'h5A and a second swap_req before the boundary.
  - Required: exactly one swap_ack.
  - Required: a following swap shows the row 3 value as it was before 8'h5A (the write was dropped).
- Coincident write+swap:
  - Stimulus: wr_en row 0 = 8'hC3 in the same cycle as swap_req.
  - Required: after swap_ack, row 0 displays 8'hC3.
- Reset mid-operation:
  - Stimulus: assert rst during row 5 SHOW while swap_pending = 1.
  - Required: row_sel, col_data and swap_pending go to 0 without waiting for a clock; no swap_ack.
  - Required: after release, the scan restarts at row 0 showing col_data 0.
